// File: rtl/oc_irq_handler.sv
// oc_irq_handler: synchronised, debounced consumer of a shared open-collector interrupt line.
// Round-robin source select, valid/ready ID handshake, one-hot ack. Define OC_IRQ_TIMEOUT_EN for PRESENT timeout.
module oc_irq_handler #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int DEB = 2,
  parameter int TMO = 16
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           irq_n,
  input  logic [N-1:0]   src_pend,
  input  logic           int_ready,
  output logic           int_valid,
  output logic [IDW-1:0] int_id,
  output logic [N-1:0]   src_ack,
  output logic           busy,
  output logic           spurious
);

  typedef enum logic [2:0] {IDLE, SCAN, PRESENT, ACK, SETTLE} state_e;

  state_e         state_q, state_d;
  logic           sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]     deb_q, deb_d;
  logic [1:0]     settle_q, settle_d;
  logic [IDW-1:0] last_q, last_d, int_id_q, int_id_d;
  logic           int_valid_q, int_valid_d, spurious_q, spurious_d;
  logic [N-1:0]   src_ack_q, src_ack_d;
  logic [IDW:0]   pick;
  logic           tmo_hit;

  // Search starts just past the last served source, so that source becomes lowest priority.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] pend, input logic [IDW-1:0] last);
    logic [IDW:0] res;
    int idx;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(last) + 1 + i;
      if (idx >= N) idx = idx - N;
      if (pend[IDW'(idx)]) res = {1'b1, IDW'(idx)};
    end
    return res;
  endfunction

  assign pick = rr_pick(src_pend, last_q);

`ifdef OC_IRQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counter stays at zero outside PRESENT, so every entry starts a fresh window.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == PRESENT) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clrn) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end

  assign tmo_hit = (state_q == PRESENT) && !int_ready && (tmo_cnt_q == TW'(TMO - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (deb_q == 4'(DEB)) state_d = SCAN;
      SCAN:    state_d = pick[IDW] ? PRESENT : SETTLE;
      PRESENT: begin
        if (int_ready)    state_d = ACK;
        else if (tmo_hit) state_d = SETTLE;
      end
      ACK:     state_d = SETTLE;
      SETTLE:  if (settle_q == 2'd2) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sync1_d     = irq_n;
    sync2_d     = sync1_q;
    deb_d       = deb_q;
    settle_d    = 2'd0;
    last_d      = last_q;
    int_id_d    = int_id_q;
    int_valid_d = int_valid_q;
    src_ack_d   = '0;
    spurious_d  = 1'b0;

    // SETTLE masks the line while the served source's release ripples through the synchroniser.
    if (state_q == SETTLE || sync2_q) deb_d = 4'd0;
    else if (deb_q != 4'(DEB))        deb_d = deb_q + 4'd1;

    if (state_q == SETTLE && settle_q != 2'd2) settle_d = settle_q + 2'd1;

    if (state_q == SCAN) begin
      if (pick[IDW]) begin
        int_id_d    = pick[IDW-1:0];
        int_valid_d = 1'b1;
      end else begin
        spurious_d  = 1'b1;
      end
    end

    if (state_q == PRESENT) begin
      if (int_ready) begin
        int_valid_d         = 1'b0;
        src_ack_d[int_id_q] = 1'b1;
      end else if (tmo_hit) begin
        int_valid_d = 1'b0;
        spurious_d  = 1'b1;
      end
    end

    if (state_q == ACK) last_d = int_id_q;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      deb_q       <= 4'd0;
      settle_q    <= 2'd0;
      last_q      <= IDW'(N - 1);
      int_id_q    <= '0;
      int_valid_q <= 1'b0;
      src_ack_q   <= '0;
      spurious_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      settle_q    <= settle_d;
      last_q      <= last_d;
      int_id_q    <= int_id_d;
      int_valid_q <= int_valid_d;
      src_ack_q   <= src_ack_d;
      spurious_q  <= spurious_d;
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    int_valid = int_valid_q;
    int_id    = int_id_q;
    src_ack   = src_ack_q;
    spurious  = spurious_q;
  end

endmodule

// File: tb/tb_oc_irq_handler.sv
// tb_oc_irq_handler: scoreboard bench for oc_irq_handler (N=4, DEB=2, TMO=16).
// Expected served IDs (or -1 for a spurious event) are queued as stimulus is set up.
module tb_oc_irq_handler;

  logic       clk = 1'b0;
  logic       clrn;
  logic       irq_n;
  logic [3:0] src_pend;
  logic       int_ready;
  logic       int_valid;
  logic [1:0] int_id;
  logic [3:0] src_ack;
  logic       busy;
  logic       spurious;

  int n_checks = 0;
  int n_fail   = 0;
  int sb_q[$];
  int ack_due  = 0;
  int ack_id   = 0;
  int ack_seen = 0;
  int spur_seen = 0;

  oc_irq_handler #(.N(4), .IDW(2), .DEB(2), .TMO(16)) dut (
    .clk(clk), .clrn(clrn), .irq_n(irq_n), .src_pend(src_pend), .int_ready(int_ready),
    .int_valid(int_valid), .int_id(int_id), .src_ack(src_ack), .busy(busy), .spurious(spurious)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic irq, input logic [3:0] pend, input logic rdy);
    irq_n     = irq;
    src_pend  = pend;
    int_ready = rdy;
  endtask

  task automatic doReset();
    clrn = 1'b0;
    step();
    step();
    clrn = 1'b1;
  endtask

  // Monitor: handshakes and spurious pulses pop the scoreboard; an ack must follow each handshake.
  always @(negedge clk) begin
    if (clrn) begin
      if (ack_due != 0) begin
        checkOutput("ack_onehot", int'(src_ack), 1 << ack_id);
        ack_due  <= 0;
        ack_seen <= ack_seen + 1;
      end else if (src_ack != 4'd0) begin
        checkOutput("stray_ack", int'(src_ack), 0);
      end
      if (int_valid && int_ready) begin
        checkOutput("sb_nonempty", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) checkOutput("served_id", int'(int_id), sb_q.pop_front());
        ack_due <= 1;
        ack_id  <= int'(int_id);
      end
      if (spurious) begin
        checkOutput("sb_nonempty", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) checkOutput("spurious_evt", int_valid ? 99 : -1, sb_q.pop_front());
        spur_seen <= spur_seen + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int base;
    int flag;

    clrn = 1'b0;
    applyStimulus(1'b0, 4'b0100, 1'b0);
    step(); step(); step();
    checkOutput("rst_valid", int'(int_valid), 0);
    checkOutput("rst_id", int'(int_id), 0);
    checkOutput("rst_ack", int'(src_ack), 0);
    checkOutput("rst_spur", int'(spurious), 0);
    checkOutput("rst_busy", int'(busy), 0);

    // Single source with latency from reset release
    clrn = 1'b1;
    repeat (5) step();
    checkOutput("lat_edge5_valid", int'(int_valid), 0);
    step();
    checkOutput("lat_edge6_valid", int'(int_valid), 1);
    checkOutput("single_id", int'(int_id), 2);
    checkOutput("single_busy", int'(busy), 1);
    sb_q.push_back(2);
    step(); step();
    checkOutput("single_hold", int'(int_valid), 1);
    int_ready = 1'b1;
    step();
    checkOutput("single_ack", int'(src_ack), 4);
    checkOutput("single_valid_drop", int'(int_valid), 0);
    int_ready = 1'b0;
    irq_n     = 1'b1;
    step();
    checkOutput("single_ack_1cyc", int'(src_ack), 0);
    step(); step();
    checkOutput("settle_busy", int'(busy), 1);
    step();
    checkOutput("settle_idle", int'(busy), 0);

    // Round-robin across sources 0 and 3
    doReset();
    base = ack_seen;
    sb_q.push_back(0); sb_q.push_back(3); sb_q.push_back(0); sb_q.push_back(3);
    applyStimulus(1'b0, 4'b1001, 1'b1);
    cyc = 0;
    while (ack_seen < base + 4 && cyc < 300) begin step(); cyc++; end
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("rr_count", ack_seen - base, 4);
    cyc = 0;
    while (busy && cyc < 20) begin step(); cyc++; end
    checkOutput("rr_idle", int'(busy), 0);

    // Spurious: line low, nothing pending
    doReset();
    base = spur_seen;
    flag = 0;
    sb_q.push_back(-1); sb_q.push_back(-1);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    cyc = 0;
    while (spur_seen < base + 2 && cyc < 100) begin
      step();
      cyc++;
      if (int_valid) flag = 1;
    end
    irq_n = 1'b1;
    checkOutput("spur_count", spur_seen - base, 2);
    checkOutput("spur_novalid", flag, 0);
    cyc = 0;
    while (busy && cyc < 20) begin step(); cyc++; end
    checkOutput("spur_idle", int'(busy), 0);

    // Glitch shorter than the debounce window
    applyStimulus(1'b1, 4'b0001, 1'b0);
    doReset();
    irq_n = 1'b0;
    step();
    irq_n = 1'b1;
    flag = 0;
    repeat (10) begin step(); if (busy) flag = 1; end
    checkOutput("glitch_busy", flag, 0);

    // Reset during PRESENT abandons the transaction
    applyStimulus(1'b0, 4'b0010, 1'b0);
    cyc = 0;
    while (!int_valid && cyc < 20) begin step(); cyc++; end
    checkOutput("midop_valid", int'(int_valid), 1);
    checkOutput("midop_id", int'(int_id), 1);
    clrn = 1'b0;
    step();
    checkOutput("midop_valid_clr", int'(int_valid), 0);
    checkOutput("midop_busy", int'(busy), 0);
    clrn  = 1'b1;
    irq_n = 1'b1;
    flag  = 0;
    repeat (8) begin step(); if (src_ack != 4'd0) flag = 1; end
    checkOutput("midop_noack", flag, 0);

`ifdef OC_IRQ_TIMEOUT_EN
    doReset();
    sb_q.push_back(-1);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    cyc = 0;
    while (!int_valid && cyc < 20) begin step(); cyc++; end
    checkOutput("tmo_valid", int'(int_valid), 1);
    repeat (15) step();
    checkOutput("tmo_hold", int'(int_valid), 1);
    step();
    checkOutput("tmo_drop", int'(int_valid), 0);
    checkOutput("tmo_spur", int'(spurious), 1);
    checkOutput("tmo_noack", int'(src_ack), 0);
    irq_n = 1'b1;
    cyc = 0;
    while (busy && cyc < 20) begin step(); cyc++; end
    checkOutput("tmo_idle", int'(busy), 0);
`endif

    step();
    checkOutput("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
